// File: rtl/memory_arbiter_if.sv
// Requester-side and RAM-side signals of the memory arbiter, bundled so the
// arbiter (slave) and its environment (master) share one declaration.
interface memory_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 2
);
  localparam int LANES = DATA_WIDTH / 8;

  logic [NUM_PORTS*DATA_WIDTH-1:0] reqAddress;
  logic [NUM_PORTS*DATA_WIDTH-1:0] reqDataWrite;
  logic [NUM_PORTS*2-1:0]          reqLength;
  logic [NUM_PORTS-1:0]            reqStore;
  logic [NUM_PORTS-1:0]            reqLoad;
  logic [NUM_PORTS-1:0]            reqLoadUnsigned;
  logic [DATA_WIDTH-1:0]           ramDataRead;
  logic                            ramReadValid;

  logic [DATA_WIDTH-1:0]           dataReadOut;
  logic [NUM_PORTS-1:0]            dataReadValid;
  logic [NUM_PORTS-1:0]            done;
  logic [NUM_PORTS-1:0]            error;
  logic [DATA_WIDTH-1:0]           addressOut;
  logic [DATA_WIDTH-1:0]           ramDataWrite;
  logic [LANES-1:0]                byteSelect;
  logic                            ramStore;
  logic                            ramLoad;
  logic                            busy;

  modport slave (
    input  reqAddress, reqDataWrite, reqLength, reqStore, reqLoad, reqLoadUnsigned,
           ramDataRead, ramReadValid,
    output dataReadOut, dataReadValid, done, error, addressOut, ramDataWrite,
           byteSelect, ramStore, ramLoad, busy
  );

  modport master (
    output reqAddress, reqDataWrite, reqLength, reqStore, reqLoad, reqLoadUnsigned,
           ramDataRead, ramReadValid,
    input  dataReadOut, dataReadValid, done, error, addressOut, ramDataWrite,
           byteSelect, ramStore, ramLoad, busy
  );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter funnelling NUM_PORTS byte-addressed load/store requesters
// onto one RAM port, with lane alignment, misalignment detection and load extension.

module memory_arbiter_lane #(
  parameter int LANE = 0,
  parameter int OB   = 2
) (
  input  logic          en,
  input  logic          wrEn,
  input  logic [OB-1:0] off,
  input  logic [3:0]    size,
  input  logic [7:0]    shByte,
  output logic          be,
  output logic [7:0]    wByte
);
  assign be    = en && (LANE >= int'(off)) && ((LANE - int'(off)) < int'(size));
  assign wByte = wrEn ? shByte : 8'h00;
endmodule

module memory_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PORTS  = 2
) (
  input logic              clk,
  input logic              reset,
  memory_arbiter_if.slave  bus
);
  localparam int LANES = DATA_WIDTH / 8;
  localparam int OB    = $clog2(LANES);
  localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] STORE = 2'd1;
  localparam logic [1:0] LOAD  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            len;
    logic                  uns;
    logic                  store;
    logic                  err;
    logic [PW-1:0]         port;
  } txnT;

  logic [1:0]            state, stateNxt;
  logic [PW-1:0]         lastGrant, pick, idx;
  logic                  anyPend;
  logic [NUM_PORTS-1:0]  pending;
  txnT                   cur;
  logic [DATA_WIDTH-1:0] dataReadReg;

  logic [DATA_WIDTH-1:0] addrArr [NUM_PORTS];
  logic [DATA_WIDTH-1:0] dataArr [NUM_PORTS];
  logic [1:0]            lenArr  [NUM_PORTS];

  genvar p;
  generate
    for (p = 0; p < NUM_PORTS; p++) begin : gPort
      assign addrArr[p] = bus.reqAddress[p*DATA_WIDTH +: DATA_WIDTH];
      assign dataArr[p] = bus.reqDataWrite[p*DATA_WIDTH +: DATA_WIDTH];
      assign lenArr[p]  = bus.reqLength[p*2 +: 2];
    end
  endgenerate

  assign pending = bus.reqStore | bus.reqLoad;

  // Search starts one past the last winner so every port gets a turn.
  always_comb begin
    anyPend = 1'b0;
    pick    = '0;
    idx     = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = PW'((int'(lastGrant) + k) % NUM_PORTS);
      if (!anyPend && pending[idx]) begin
        anyPend = 1'b1;
        pick    = idx;
      end
    end
  end

  logic [DATA_WIDTH-1:0] gAddr;
  logic [1:0]            gLen;
  logic [3:0]            gSize;
  logic [OB-1:0]         gOff;
  logic                  gLegal;

  assign gAddr  = addrArr[pick];
  assign gLen   = lenArr[pick];
  assign gSize  = 4'(1) << gLen;
  assign gOff   = gAddr[OB-1:0];
  assign gLegal = (int'(gSize) <= LANES) && ((int'(gOff) & (int'(gSize) - 1)) == 0);

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (anyPend) stateNxt = !gLegal ? RESP : (bus.reqStore[pick] ? STORE : LOAD);
      STORE:   stateNxt = RESP;
      LOAD:    if (bus.ramReadValid) stateNxt = RESP;
      default: stateNxt = IDLE;
    endcase
  end

  logic [OB-1:0]         curOff;
  logic [3:0]            curSize;
  logic [6:0]            sizeBits;
  logic [DATA_WIDTH-1:0] storeShift, readShift, loadFmt;
  logic                  signBit;

  assign curOff     = cur.addr[OB-1:0];
  assign curSize    = 4'(1) << cur.len;
  assign sizeBits   = 7'(8) << cur.len;
  assign storeShift = cur.data << {curOff, 3'b000};
  assign readShift  = bus.ramDataRead >> {curOff, 3'b000};

  always_comb begin
    case (cur.len)
      2'd0:    signBit = readShift[7];
      2'd1:    signBit = readShift[15];
      2'd2:    signBit = readShift[31];
      default: signBit = readShift[DATA_WIDTH-1];
    endcase
    loadFmt = '0;
    for (int b = 0; b < DATA_WIDTH; b++)
      loadFmt[b] = (b < int'(sizeBits)) ? readShift[b] : (signBit & ~cur.uns);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      lastGrant   <= PW'(NUM_PORTS - 1);
      cur         <= '0;
      dataReadReg <= '0;
    end else begin
      state <= stateNxt;
      if (state == IDLE && anyPend) begin
        lastGrant <= pick;
        cur.addr  <= gAddr;
        cur.data  <= dataArr[pick];
        cur.len   <= gLen;
        cur.uns   <= bus.reqLoadUnsigned[pick];
        cur.store <= bus.reqStore[pick];
        cur.err   <= !gLegal;
        cur.port  <= pick;
      end
      if (state == LOAD && bus.ramReadValid)
        dataReadReg <= loadFmt;
    end
  end

  logic                  ramActive;
  logic [LANES-1:0]      be;
  logic [DATA_WIDTH-1:0] wrData;
  logic [NUM_PORTS-1:0]  portHot;

  assign ramActive = (state == STORE) || (state == LOAD);

  genvar j;
  generate
    for (j = 0; j < LANES; j++) begin : gLane
      memory_arbiter_lane #(.LANE(j), .OB(OB)) uLane (
        .en     (ramActive),
        .wrEn   (state == STORE),
        .off    (curOff),
        .size   (curSize),
        .shByte (storeShift[8*j +: 8]),
        .be     (be[j]),
        .wByte  (wrData[8*j +: 8])
      );
    end
  endgenerate

  assign portHot           = NUM_PORTS'(1) << cur.port;
  assign bus.addressOut    = ramActive ? {cur.addr[DATA_WIDTH-1:OB], {OB{1'b0}}} : '0;
  assign bus.ramDataWrite  = wrData;
  assign bus.byteSelect    = be;
  assign bus.ramStore      = (state == STORE);
  assign bus.ramLoad       = (state == LOAD);
  assign bus.busy          = (state != IDLE);
  assign bus.done          = (state == RESP) ? portHot : '0;
  assign bus.error         = (state == RESP && cur.err) ? portHot : '0;
  assign bus.dataReadValid = (state == RESP && !cur.store && !cur.err) ? portHot : '0;
  assign bus.dataReadOut   = dataReadReg;
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: 32-bit/2-port and 64-bit/4-port instances.
module tb_memory_arbiter;
  logic clk = 1'b0;
  logic rstN;
  int   nChecks = 0;
  int   nFails  = 0;
  logic sawLoad;

  always #5 clk = ~clk;

  memory_arbiter_if #(.DATA_WIDTH(32), .NUM_PORTS(2)) b32();
  memory_arbiter_if #(.DATA_WIDTH(64), .NUM_PORTS(4)) b64();

  memory_arbiter #(.DATA_WIDTH(32), .NUM_PORTS(2)) dut32 (.clk(clk), .reset(rstN), .bus(b32));
  memory_arbiter #(.DATA_WIDTH(64), .NUM_PORTS(4)) dut64 (.clk(clk), .reset(rstN), .bus(b64));

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic req32(int pt, logic [31:0] addr, logic [31:0] data, logic [1:0] len,
                       logic st, logic ld, logic uns);
    b32.reqAddress[pt*32 +: 32]   = addr;
    b32.reqDataWrite[pt*32 +: 32] = data;
    b32.reqLength[pt*2 +: 2]      = len;
    b32.reqStore[pt]              = st;
    b32.reqLoad[pt]               = ld;
    b32.reqLoadUnsigned[pt]       = uns;
  endtask

  task automatic req64(int pt, logic [63:0] addr, logic [63:0] data, logic [1:0] len,
                       logic st, logic ld, logic uns);
    b64.reqAddress[pt*64 +: 64]   = addr;
    b64.reqDataWrite[pt*64 +: 64] = data;
    b64.reqLength[pt*2 +: 2]      = len;
    b64.reqStore[pt]              = st;
    b64.reqLoad[pt]               = ld;
    b64.reqLoadUnsigned[pt]       = uns;
  endtask

  task automatic waitDone(output logic [1:0] d);
    d = '0;
    for (int c = 0; c < 10 && d == 0; c++) begin
      @(negedge clk);
      if (b32.ramLoad) sawLoad = 1'b1;
      d = b32.done;
    end
    if (d == 0) check("rr_timeout", 64'(d), 64'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] d;
    rstN = 1'b0;
    b32.reqAddress = '0; b32.reqDataWrite = '0; b32.reqLength = '0;
    b32.reqStore = '0; b32.reqLoad = '0; b32.reqLoadUnsigned = '0;
    b32.ramDataRead = '0; b32.ramReadValid = 1'b0;
    b64.reqAddress = '0; b64.reqDataWrite = '0; b64.reqLength = '0;
    b64.reqStore = '0; b64.reqLoad = '0; b64.reqLoadUnsigned = '0;
    b64.ramDataRead = '0; b64.ramReadValid = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_busy",  64'(b32.busy), 0);
    check("rst_done",  64'(b32.done), 0);
    check("rst_err",   64'(b32.error), 0);
    check("rst_dv",    64'(b32.dataReadValid), 0);
    check("rst_ctl",   64'({b32.ramStore, b32.ramLoad, b32.byteSelect}), 0);
    check("rst_addr",  64'(b32.addressOut), 0);
    check("rst_wdata", 64'(b32.ramDataWrite), 0);
    check("rst_rdata", 64'(b32.dataReadOut), 0);
    rstN = 1'b1;
    @(negedge clk);

    // word store, port 0
    req32(0, 32'h100, 32'hDEADBEEF, 2'd2, 1, 0, 0);
    @(negedge clk);
    check("st_ramStore", 64'(b32.ramStore), 1);
    check("st_addr",     64'(b32.addressOut), 64'h100);
    check("st_be",       64'(b32.byteSelect), 64'hF);
    check("st_wdata",    64'(b32.ramDataWrite), 64'hDEADBEEF);
    check("st_noDone",   64'(b32.done), 0);
    @(negedge clk);
    check("st_done",     64'(b32.done), 64'b01);
    check("st_strobeOff",64'(b32.ramStore), 0);
    check("st_noErr",    64'(b32.error), 0);
    req32(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("st_idle", 64'(b32.busy), 0);

    // half store at offset 2, port 1
    req32(1, 32'h102, 32'h0000ABCD, 2'd1, 1, 0, 0);
    @(negedge clk);
    check("sh_be",    64'(b32.byteSelect), 64'b1100);
    check("sh_wdata", 64'(b32.ramDataWrite), 64'hABCD0000);
    check("sh_addr",  64'(b32.addressOut), 64'h100);
    @(negedge clk);
    check("sh_done",  64'(b32.done), 64'b10);
    req32(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // stray read-valid while idle
    b32.ramDataRead = 32'h12345678; b32.ramReadValid = 1'b1;
    @(negedge clk);
    check("stray_busy", 64'(b32.busy), 0);
    check("stray_dv",   64'(b32.dataReadValid), 0);
    b32.ramReadValid = 1'b0;

    // signed byte load, port 1, offset 3
    req32(1, 32'h103, 0, 2'd0, 0, 1, 0);
    @(negedge clk);
    check("lb_ramLoad", 64'(b32.ramLoad), 1);
    check("lb_addr",    64'(b32.addressOut), 64'h100);
    check("lb_be",      64'(b32.byteSelect), 64'b1000);
    @(negedge clk);
    check("lb_hold",    64'(b32.ramLoad), 1);
    b32.ramDataRead = 32'h80FF0000; b32.ramReadValid = 1'b1;
    @(negedge clk);
    check("lb_dv",     64'(b32.dataReadValid), 64'b10);
    check("lb_done",   64'(b32.done), 64'b10);
    check("lb_data",   64'(b32.dataReadOut), 64'hFFFFFF80);
    check("lb_loadOff",64'(b32.ramLoad), 0);
    b32.ramReadValid = 1'b0;
    req32(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("lb_keep",   64'(b32.dataReadOut), 64'hFFFFFF80);
    check("lb_dvOff",  64'(b32.dataReadValid), 0);

    // unsigned byte load
    req32(1, 32'h103, 0, 2'd0, 0, 1, 1);
    @(negedge clk);
    b32.ramDataRead = 32'h80FF0000; b32.ramReadValid = 1'b1;
    @(negedge clk);
    check("lbu_data", 64'(b32.dataReadOut), 64'h00000080);
    check("lbu_dv",   64'(b32.dataReadValid), 64'b10);
    b32.ramReadValid = 1'b0;
    req32(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // misaligned half load
    req32(0, 32'h101, 0, 2'd1, 0, 1, 0);
    @(negedge clk);
    check("mis_ramLoad", 64'(b32.ramLoad), 0);
    check("mis_done",    64'(b32.done), 64'b01);
    check("mis_err",     64'(b32.error), 64'b01);
    check("mis_dv",      64'(b32.dataReadValid), 0);
    req32(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // both ports continuously from reset; port 1 also asserts load (store wins)
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    sawLoad = 1'b0;
    req32(0, 32'h200, 32'h11111111, 2'd2, 1, 0, 0);
    req32(1, 32'h300, 32'h22222222, 2'd2, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      waitDone(d);
      check($sformatf("rr_grant%0d", i), 64'(d), (i % 2 == 0) ? 64'b01 : 64'b10);
    end
    check("rr_storeOnly", 64'(sawLoad), 0);
    req32(0, 0, 0, 0, 0, 0, 0);
    req32(1, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);

    // reset during LOAD, then a late read-valid
    req32(0, 32'h200, 0, 2'd2, 0, 1, 0);
    @(negedge clk);
    check("ab_inLoad", 64'(b32.ramLoad), 1);
    rstN = 1'b0;
    #1;
    check("ab_busy",  64'(b32.busy), 0);
    check("ab_outs",  64'({b32.ramLoad, b32.ramStore, b32.byteSelect, b32.done, b32.error}), 0);
    check("ab_addr",  64'(b32.addressOut), 0);
    check("ab_rdata", 64'(b32.dataReadOut), 0);
    req32(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rstN = 1'b1;
    b32.ramDataRead = 32'hCAFEF00D; b32.ramReadValid = 1'b1;
    @(negedge clk);
    check("ab_noDone", 64'(b32.done), 0);
    check("ab_noDv",   64'(b32.dataReadValid), 0);
    check("ab_idle",   64'(b32.busy), 0);
    b32.ramReadValid = 1'b0;
    @(negedge clk);

    // 64-bit, 4 ports
    req64(2, 64'h8, 64'h1122334455667788, 2'd3, 1, 0, 0);
    @(negedge clk);
    check("w64_be",    64'(b64.byteSelect), 64'hFF);
    check("w64_str",   64'(b64.ramStore), 1);
    check("w64_addr",  b64.addressOut, 64'h8);
    check("w64_wdata", b64.ramDataWrite, 64'h1122334455667788);
    @(negedge clk);
    check("w64_done",  64'(b64.done), 64'b0100);
    check("w64_noErr", 64'(b64.error), 0);
    req64(2, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    req64(3, 64'h4, 64'hAAAA, 2'd3, 1, 0, 0);
    @(negedge clk);
    check("e64_done", 64'(b64.done), 64'b1000);
    check("e64_err",  64'(b64.error), 64'b1000);
    check("e64_str",  64'(b64.ramStore), 0);
    req64(3, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    // signed word load from upper half of a 64-bit beat
    req64(0, 64'hC, 0, 2'd2, 0, 1, 0);
    @(negedge clk);
    check("l64_be", 64'(b64.byteSelect), 64'hF0);
    b64.ramDataRead = 64'h80000000_00000000; b64.ramReadValid = 1'b1;
    @(negedge clk);
    check("l64_data", b64.dataReadOut, 64'hFFFFFFFF80000000);
    check("l64_dv",   64'(b64.dataReadValid), 64'b0001);
    b64.ramReadValid = 1'b0;
    req64(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, RAM/requester data and address width (multiple of 8, 32 or 64); NUM_PORTS, default 2, requester count (1..8); LANES = DATA_WIDTH/8 (derived, not overridable).
REQ-002 Ports SHALL be:
- clk  in  1  clock, rising edge;
- reset  in  1  asynchronous, active-low reset;
- reqAddress  in  NUM_PORTS*DATA_WIDTH  per-port byte address (port i at slice i);
- reqDataWrite  in  NUM_PORTS*DATA_WIDTH  per-port store data, LSB-justified;
- reqLength  in  NUM_PORTS*2  per-port size: 0 byte, 1 half, 2 word, 3 double;
- reqStore  in  NUM_PORTS  per-port store request;
- reqLoad  in  NUM_PORTS  per-port load request;
- reqLoadUnsigned  in  NUM_PORTS  per-port zero-extend select;
- ramDataRead  in  DATA_WIDTH  RAM read data;
- ramReadValid  in  1  RAM read data valid;
- dataReadOut  out  DATA_WIDTH  formatted load data, shared bus;
- dataReadValid  out  NUM_PORTS  one-hot load-data valid;
- done  out  NUM_PORTS  one-hot transaction complete;
- error  out  NUM_PORTS  one-hot misaligned/illegal completion;
- addressOut  out  DATA_WIDTH  RAM address, low log2(LANES) bits zero;
- ramDataWrite  out  DATA_WIDTH  lane-shifted store data;
- byteSelect  out  LANES  active-high byte enables;
- ramStore  out  1  RAM write strobe;
- ramLoad  out  1  RAM read request;
- busy  out  1  state != IDLE.

Function
REQ-003 FSM states SHALL be IDLE, STORE, LOAD, RESP; one transaction in flight.
REQ-004 Port i is pending when reqStore[i] or reqLoad[i]; if both, store only.
REQ-005 In IDLE with any port pending, the arbiter SHALL grant round-robin, searching from port (lastGrant+1) mod NUM_PORTS, and register address, data, length, unsigned and op of the granted port.
REQ-006 Grant SHALL set lastGrant to the granted port; non-granted ports wait with no indication.
REQ-007 Access size = 2^length bytes, offset = address mod LANES; legal iff size <= LANES and offset mod size == 0.
REQ-008 Illegal grant SHALL go IDLE -> RESP: no RAM strobe, next cycle done[i]=1 and error[i]=1.
REQ-009 Legal store: IDLE -> STORE; ramStore=1 exactly one cycle, byteSelect = size ones shifted left by offset, ramDataWrite = reqDataWrite shifted left 8*offset bits; then RESP.
REQ-010 Legal load: IDLE -> LOAD; ramLoad=1, address/byteSelect held every cycle until ramReadValid=1, then RESP.
REQ-011 Load data SHALL be ramDataRead shifted right 8*offset bits, truncated to size, sign-extended (unsigned=0) or zero-extended (unsigned=1) to DATA_WIDTH.
REQ-012 RESP SHALL last one cycle: done[g]=1; for loads also dataReadValid[g]=1 with dataReadOut valid; then IDLE.
REQ-013 Latency: store grant at cycle N -> ramStore N+1 -> done N+2; load with ramReadValid at cycle M -> done/dataReadValid M+1.
REQ-014 Requesters SHALL hold request signals stable until done; the arbiter does not re-sample them after grant.
REQ-015 ramReadValid outside LOAD SHALL be ignored.
REQ-016 A port still requesting in the IDLE cycle after its RESP SHALL be treated as a new request, subject to REQ-005.
REQ-017 dataReadOut SHALL hold its last value outside RESP; ramStore, ramLoad, byteSelect SHALL be 0 outside STORE/LOAD.

Reset
REQ-018 With reset=0, all outputs SHALL be 0, state IDLE, lastGrant = NUM_PORTS-1 (port 0 first).
REQ-019 Reset mid-transaction SHALL abort it with no done or error pulse; a late ramReadValid after release is ignored.

Verification
REQ-020 Scenarios, default parameters unless noted:
- Store word, port 0, addr 0x100, data 0xDEADBEEF -> cycle N+1 ramStore=1, addressOut 0x100, byteSelect 4'b1111; done[0] at N+2.
- Load byte, port 1, addr 0x103, RAM 0x80FF_0000, signed -> dataReadOut 0xFFFFFF80; unsigned -> 0x00000080; dataReadValid[1] one cycle after ramReadValid.
- Both ports request continuously from reset -> grants 0,1,0,1; each done one-hot.
- Half load at addr 0x101 -> no ramLoad; done[0]=error[0]=1 next cycle.
- reset=0 during LOAD, then ramReadValid pulsed -> no done, all outputs 0, state IDLE.
- DATA_WIDTH=64, NUM_PORTS=4, double store at 0x8 -> byteSelect 8'hFF; store at 0x4 -> error.
